// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: merges the CPU's sram-style inst and data ports into a single
// AXI-Lite master. There is one transaction outstanding at a time; requests are
// arbitrated in IDLE and completions are returned as one-cycle data_ok pulses.
//
// Ports:
//   clk, resetn                        clock, async active-low reset
//   inst_req/addr/addr_ok/data_ok/rdata    instruction read port
//   data_req/wstrb/addr/wdata/addr_ok/data_ok/rdata  data read/write port
//   araddr/arvalid/arready             AXI read address channel
//   rdata/rvalid/rready                AXI read data channel
//   awaddr/awvalid/awready             AXI write address channel
//   wdata/wstrb/wvalid/wready          AXI write data channel
//   bvalid/bready                      AXI write response channel
module cpu_axi_bridge #(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WRESP = 3'd4
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;
    logic          owner_data;
    logic          aw_done;
    logic          w_done;
    logic          grant_inst;
    logic          grant_data;
    logic          aw_fin;
    logic          w_fin;

    // Channel valids/readies decode straight from registered state.
    assign arvalid = (state == RADDR);
    assign rready  = (state == RDATA);
    assign awvalid = (state == WADDR) && !aw_done;
    assign wvalid  = (state == WADDR) && !w_done;
    assign bready  = (state == WRESP);
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;

    // Each write channel counts as finished once its handshake has happened.
    assign aw_fin  = aw_done || awready;
    assign w_fin   = w_done  || wready;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration, accept handshakes and next-state decode.
    always_comb begin
        next_state   = state;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        case (state)
            IDLE: begin
                // Held off during reset so every output reads 0 while resetn is low.
                if (resetn) begin
                    grant_data = data_req && (DATA_PRIO || !inst_req);
                    grant_inst = inst_req && !grant_data;
                end
                inst_addr_ok = grant_inst;
                data_addr_ok = grant_data;
                if (grant_data) begin
                    next_state = (data_wstrb != SW'(0)) ? WADDR : RADDR;
                end else if (grant_inst) begin
                    next_state = RADDR;
                end
            end
            RADDR: if (arready) next_state = RDATA;
            RDATA: if (rvalid) next_state = IDLE;
            WADDR: if (aw_fin && w_fin) next_state = WRESP;
            WRESP: if (bvalid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch, write-channel progress flags and read data / completion pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            owner_data   <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
        end else begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;

            if (grant_data) begin
                addr_q     <= data_addr;
                wdata_q    <= data_wdata;
                wstrb_q    <= data_wstrb;
                owner_data <= 1'b1;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end else if (grant_inst) begin
                addr_q     <= inst_addr;
                wdata_q    <= '0;
                wstrb_q    <= '0;
                owner_data <= 1'b0;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end

            if (state == RDATA && rvalid) begin
                if (owner_data) begin
                    data_rdata   <= rdata;
                    data_data_ok <= 1'b1;
                end else begin
                    inst_rdata   <= rdata;
                    inst_data_ok <= 1'b1;
                end
            end

            if (state == WADDR) begin
                if (awready) aw_done <= 1'b1;
                if (wready)  w_done  <= 1'b1;
            end

            // Write completion never touches data_rdata.
            if (state == WRESP && bvalid) begin
                data_data_ok <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed, table-driven bench for cpu_axi_bridge. Each table row is one clock
// cycle: CPU and AXI-slave inputs applied after the falling edge, all outputs
// compared just before the next rising edge.
module tb_cpu_axi_bridge;

    localparam logic [8:0] F_IAOK = 9'h100;
    localparam logic [8:0] F_DAOK = 9'h080;
    localparam logic [8:0] F_IDOK = 9'h040;
    localparam logic [8:0] F_DDOK = 9'h020;
    localparam logic [8:0] F_AR   = 9'h010;
    localparam logic [8:0] F_R    = 9'h008;
    localparam logic [8:0] F_AW   = 9'h004;
    localparam logic [8:0] F_W    = 9'h002;
    localparam logic [8:0] F_B    = 9'h001;

    localparam logic [4:0] I_ARR = 5'h10;
    localparam logic [4:0] I_RV  = 5'h08;
    localparam logic [4:0] I_AWR = 5'h04;
    localparam logic [4:0] I_WR  = 5'h02;
    localparam logic [4:0] I_BV  = 5'h01;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dstrb;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [4:0]  ax;
        logic [31:0] rd;
        logic [8:0]  fl;
        logic [31:0] eaddr;
        logic [3:0]  ewstrb;
        logic [31:0] ewdata;
        logic [31:0] eir;
        logic [31:0] edr;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cpu_axi_bridge #(.DATA_PRIO(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    function automatic logic [8:0] flags();
        return {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                arvalid, rready, awvalid, wvalid, bready};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic [3:0] dstrb, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic [4:0] ax,
                       input logic [31:0] rd, input logic [8:0] fl,
                       input logic [31:0] eaddr, input logic [3:0] ewstrb,
                       input logic [31:0] ewdata, input logic [31:0] eir,
                       input logic [31:0] edr);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dstrb = dstrb;
        v.daddr = daddr; v.dwdata = dwdata; v.ax = ax; v.rd = rd; v.fl = fl;
        v.eaddr = eaddr; v.ewstrb = ewstrb; v.ewdata = ewdata;
        v.eir = eir; v.edr = edr;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic run_vectors();
        foreach (vecs[i]) begin
            @(negedge clk);
            inst_req   = vecs[i].ireq;  inst_addr  = vecs[i].iaddr;
            data_req   = vecs[i].dreq;  data_wstrb = vecs[i].dstrb;
            data_addr  = vecs[i].daddr; data_wdata = vecs[i].dwdata;
            {arready, rvalid, awready, wready, bvalid} = vecs[i].ax;
            rdata      = vecs[i].rd;
            #1;
            chk($sformatf("v%0d_flags", i), 32'(flags()), 32'(vecs[i].fl));
            chk($sformatf("v%0d_inst_rdata", i), inst_rdata, vecs[i].eir);
            chk($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].edr);
            if ((vecs[i].fl & F_AR) != 9'h0)
                chk($sformatf("v%0d_araddr", i), araddr, vecs[i].eaddr);
            if ((vecs[i].fl & F_AW) != 9'h0)
                chk($sformatf("v%0d_awaddr", i), awaddr, vecs[i].eaddr);
            if ((vecs[i].fl & F_W) != 9'h0) begin
                chk($sformatf("v%0d_wstrb", i), 32'(wstrb), 32'(vecs[i].ewstrb));
                chk($sformatf("v%0d_wdata", i), wdata, vecs[i].ewdata);
            end
        end
        vecs.delete();
    endtask

    initial begin
        drive_idle();
        resetn = 1'b0;
        inst_req = 1'b1;
        inst_addr = 32'hBFC00000;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_flags", 32'(flags()), 32'h0);
        chk("reset_araddr", araddr, 32'h0);
        chk("reset_awaddr", awaddr, 32'h0);
        chk("reset_wdata", wdata, 32'h0);
        chk("reset_wstrb", 32'(wstrb), 32'h0);
        chk("reset_inst_rdata", inst_rdata, 32'h0);
        chk("reset_data_rdata", data_rdata, 32'h0);
        @(negedge clk);
        inst_req = 1'b0;
        resetn = 1'b1;

        // Zero-wait inst read.
        add(1, 32'hBFC00000, 0, 4'h0, 0, 0, 5'h0, 0, F_IAOK, 0, 0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, I_ARR, 0, F_AR, 32'hBFC00000, 0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, I_RV, 32'h3C080001, F_R, 0, 0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, F_IDOK, 0, 0, 0, 32'h3C080001, 0);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, 9'h0, 0, 0, 0, 32'h3C080001, 0);

        // Simultaneous requests: data wins, inst granted in the data_ok cycle.
        add(1, 32'hBFC00004, 1, 4'h0, 32'h80001000, 0, 5'h0, 0, F_DAOK, 0, 0, 0, 32'h3C080001, 0);
        add(1, 32'hBFC00004, 0, 4'h0, 0, 0, I_ARR, 0, F_AR, 32'h80001000, 0, 0, 32'h3C080001, 0);
        add(1, 32'hBFC00004, 0, 4'h0, 0, 0, I_RV, 32'h11112222, F_R, 0, 0, 0, 32'h3C080001, 0);
        add(1, 32'hBFC00004, 0, 4'h0, 0, 0, 5'h0, 0, F_DDOK | F_IAOK, 0, 0, 0, 32'h3C080001, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, I_ARR, 0, F_AR, 32'hBFC00004, 0, 0, 32'h3C080001, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, I_RV, 32'h22223333, F_R, 0, 0, 0, 32'h3C080001, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, F_IDOK, 0, 0, 0, 32'h22223333, 32'h11112222);

        // Byte write, awready two cycles ahead of wready.
        add(0, 0, 1, 4'b0010, 32'h80000005, 32'h0000AB00, 5'h0, 0, F_DAOK, 0, 0, 0, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, I_AWR, 0, F_AW | F_W, 32'h80000005, 4'b0010, 32'h0000AB00, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, F_W, 0, 4'b0010, 32'h0000AB00, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, I_WR, 0, F_W, 0, 4'b0010, 32'h0000AB00, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, F_B, 0, 0, 0, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, I_BV, 0, F_B, 0, 0, 0, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, F_DDOK, 0, 0, 0, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, 9'h0, 0, 0, 0, 32'h22223333, 32'h11112222);

        // Zero-wait write: both write handshakes in the same cycle.
        add(0, 0, 1, 4'hF, 32'h80000010, 32'hDEADBEEF, 5'h0, 0, F_DAOK, 0, 0, 0, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, I_AWR | I_WR, 0, F_AW | F_W, 32'h80000010, 4'hF, 32'hDEADBEEF, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, I_BV, 0, F_B, 0, 0, 0, 32'h22223333, 32'h11112222);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, F_DDOK, 0, 0, 0, 32'h22223333, 32'h11112222);

        // arready stalled five cycles while inst_req waits.
        add(1, 32'hBFC00008, 1, 4'h0, 32'h80002000, 0, 5'h0, 0, F_DAOK, 0, 0, 0, 32'h22223333, 32'h11112222);
        for (int k = 0; k < 5; k++)
            add(1, 32'hBFC00008, 0, 4'h0, 0, 0, 5'h0, 0, F_AR, 32'h80002000, 0, 0, 32'h22223333, 32'h11112222);
        add(1, 32'hBFC00008, 0, 4'h0, 0, 0, I_ARR, 0, F_AR, 32'h80002000, 0, 0, 32'h22223333, 32'h11112222);
        add(1, 32'hBFC00008, 0, 4'h0, 0, 0, I_RV, 32'h44445555, F_R, 0, 0, 0, 32'h22223333, 32'h11112222);
        add(1, 32'hBFC00008, 0, 4'h0, 0, 0, 5'h0, 0, F_DDOK | F_IAOK, 0, 0, 0, 32'h22223333, 32'h44445555);
        add(0, 0, 0, 4'h0, 0, 0, I_ARR, 0, F_AR, 32'hBFC00008, 0, 0, 32'h22223333, 32'h44445555);
        add(0, 0, 0, 4'h0, 0, 0, I_RV, 32'h55556666, F_R, 0, 0, 0, 32'h22223333, 32'h44445555);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, F_IDOK, 0, 0, 0, 32'h55556666, 32'h44445555);
        run_vectors();

        // Reset while waiting in RDATA.
        @(negedge clk);
        drive_idle();
        inst_req = 1'b1; inst_addr = 32'hBFC00010;
        @(negedge clk);
        inst_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #1;
        chk("rst_pre_rready", 32'(rready), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_flags", 32'(flags()), 32'h0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        rvalid = 1'b1; rdata = 32'hDEAD0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rvalid = 1'b0;
            #1;
            chk($sformatf("rst_after%0d_flags", k), 32'(flags()), 32'h0);
            chk($sformatf("rst_after%0d_inst_rdata", k), inst_rdata, 32'h0);
        end

        // Normal service after reset.
        add(1, 32'hBFC00010, 0, 4'h0, 0, 0, 5'h0, 0, F_IAOK, 0, 0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, I_ARR, 0, F_AR, 32'hBFC00010, 0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, I_RV, 32'h12345678, F_R, 0, 0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, F_IDOK, 0, 0, 0, 32'h12345678, 0);
        add(0, 0, 0, 4'h0, 0, 0, 5'h0, 0, 9'h0, 0, 0, 0, 32'h12345678, 0);
        run_vectors();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
